// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Opcode map, state encodings and strobe bundle shared by the
//               hardwired control sequencer and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        RESET = 4'd0,
        T0    = 4'd1,
        T1    = 4'd2,
        T2    = 4'd3,
        T3    = 4'd4,
        T4    = 4'd5,
        T5    = 4'd6,
        T6    = 4'd7,
        T7    = 4'd8,
        HALT  = 4'd9
    } state_t;

    typedef struct packed {
        logic       PCout;
        logic       Zlowout;
        logic       MDRout;
        logic       Cout;
        logic       Rout;
        logic       BAout;
        logic       enableMAR;
        logic       enableMDR;
        logic       enableIR;
        logic       enableY;
        logic       enableZ;
        logic       enablePC;
        logic       enableRAM;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rin;
        logic       IncPC;
        logic       Read;
        logic       conIn;
        logic [4:0] opcode;
        logic       run;
    } strobes_t;

    function automatic logic is_defined_op(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_BR, OP_NOP, OP_HALT: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Step on which an instruction retires; undefined opcodes retire at T3 like nop.
    function automatic logic is_last_step(input state_t s, input logic [4:0] op);
        case (s)
            T3:      return (op == OP_NOP) || (op == OP_HALT) || !is_defined_op(op);
            T5:      return (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
                            (op == OP_AND) || (op == OP_OR)  || (op == OP_ADDI);
            T6:      return (op == OP_BR);
            T7:      return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Sequencer <-> DataPath bundle: IR/condition/stop inputs and
//               every DataPath control strobe. illegal exists only when
//               CTRL_ILLEGAL_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
    logic [31:0] IR;
    logic        con_ff;
    logic        stop;
    logic        PCout, Zlowout, MDRout, Cout, Rout, BAout;
    logic        enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableRAM;
    logic        Gra, Grb, Grc, Rin;
    logic        IncPC, Read, conIn;
    logic [4:0]  opcode;
    logic        run;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    modport master (
        input  IR, con_ff, stop,
        output PCout, Zlowout, MDRout, Cout, Rout, BAout,
        output enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableRAM,
        output Gra, Grb, Grc, Rin, IncPC, Read, conIn, opcode, run
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output IR, con_ff, stop,
        input  PCout, Zlowout, MDRout, Cout, Rout, BAout,
        input  enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableRAM,
        input  Gra, Grb, Grc, Rin, IncPC, Read, conIn, opcode, run
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational Moore decode of (step, opcode, con_ff) into the
//               DataPath strobe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  wire state_t     state,
    input  wire logic [4:0] op,
    input  wire logic       con_ff,
    output strobes_t        strobes
);

    always_comb begin
        strobes     = '0;
        strobes.run = (state != RESET) && (state != HALT);
        case (state)
            T0: begin strobes.PCout = 1'b1; strobes.enableMAR = 1'b1; strobes.IncPC = 1'b1; end
            T1: begin strobes.Read = 1'b1; strobes.enableMDR = 1'b1; end
            T2: begin strobes.MDRout = 1'b1; strobes.enableIR = 1'b1; end
            T3: case (op)
                OP_LD, OP_LDI, OP_ST: begin
                    strobes.Grb = 1'b1; strobes.BAout = 1'b1; strobes.enableY = 1'b1;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                    strobes.Grb = 1'b1; strobes.Rout = 1'b1; strobes.enableY = 1'b1;
                end
                OP_BR: begin strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.conIn = 1'b1; end
                default: ;
            endcase
            T4: case (op)
                OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                    strobes.Cout = 1'b1; strobes.enableZ = 1'b1; strobes.opcode = ALU_ADD;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    strobes.Grc = 1'b1; strobes.Rout = 1'b1; strobes.enableZ = 1'b1;
                    strobes.opcode = op;
                end
                OP_BR: begin strobes.PCout = 1'b1; strobes.enableY = 1'b1; end
                default: ;
            endcase
            T5: case (op)
                OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                    strobes.Zlowout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end
                OP_LD, OP_ST: begin strobes.Zlowout = 1'b1; strobes.enableMAR = 1'b1; end
                OP_BR: begin
                    strobes.Cout = 1'b1; strobes.enableZ = 1'b1; strobes.opcode = ALU_ADD;
                end
                default: ;
            endcase
            T6: case (op)
                OP_LD: begin strobes.Read = 1'b1; strobes.enableMDR = 1'b1; end
                OP_ST: begin strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.enableMDR = 1'b1; end
                OP_BR: begin strobes.Zlowout = con_ff; strobes.enablePC = con_ff; end
                default: ;
            endcase
            T7: case (op)
                OP_LD: begin strobes.MDRout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1; end
                OP_ST: strobes.enableRAM = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired control unit: step register, next-step logic and
//               strobe decode for the DataPath. Optional opcode trap is
//               enabled with CTRL_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5,
    parameter int STW = 4
) (
    input wire logic             Clock,
    input wire logic             clear,
    control_sequencer_if.master  bus
);

    logic [STW-1:0] r_state;
    logic [STW-1:0] w_next;
    logic [OPW-1:0] w_op;
    strobes_t       w_strobes;

    assign w_op = bus.IR[31 -: OPW];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_illegal_next;
    assign bus.illegal = r_illegal;
`endif

    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state <= RESET;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal <= w_illegal_next;
`endif
        end
    end

    // stop is only consulted on an instruction's retiring step.
    always_comb begin
        w_next = r_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_illegal_next = r_illegal;
`endif
        case (state_t'(r_state))
            RESET: w_next = T0;
            HALT:  w_next = HALT;
            T0, T1, T2, T3, T4, T5, T6, T7: begin
                if (r_state == T3 && w_op == OP_HALT) begin
                    w_next = HALT;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                else if (r_state == T3 && !is_defined_op(w_op)) begin
                    w_next         = HALT;
                    w_illegal_next = 1'b1;
                end
`endif
                else if (is_last_step(state_t'(r_state), w_op)) begin
                    w_next = bus.stop ? HALT : T0;
                end else begin
                    w_next = r_state + 1'b1;
                end
            end
            default: w_next = RESET;
        endcase
    end

    ctrl_decode u_decode (
        .state   (state_t'(r_state)),
        .op      (w_op),
        .con_ff  (bus.con_ff),
        .strobes (w_strobes)
    );

    assign bus.PCout     = w_strobes.PCout;
    assign bus.Zlowout   = w_strobes.Zlowout;
    assign bus.MDRout    = w_strobes.MDRout;
    assign bus.Cout      = w_strobes.Cout;
    assign bus.Rout      = w_strobes.Rout;
    assign bus.BAout     = w_strobes.BAout;
    assign bus.enableMAR = w_strobes.enableMAR;
    assign bus.enableMDR = w_strobes.enableMDR;
    assign bus.enableIR  = w_strobes.enableIR;
    assign bus.enableY   = w_strobes.enableY;
    assign bus.enableZ   = w_strobes.enableZ;
    assign bus.enablePC  = w_strobes.enablePC;
    assign bus.enableRAM = w_strobes.enableRAM;
    assign bus.Gra       = w_strobes.Gra;
    assign bus.Grb       = w_strobes.Grb;
    assign bus.Grc       = w_strobes.Grc;
    assign bus.Rin       = w_strobes.Rin;
    assign bus.IncPC     = w_strobes.IncPC;
    assign bus.Read      = w_strobes.Read;
    assign bus.conIn     = w_strobes.conIn;
    assign bus.opcode    = w_strobes.opcode;
    assign bus.run       = w_strobes.run;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer; observes
//               the full strobe/opcode/run vector every step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam logic [19:0] c_PCOUT  = 20'h80000;
    localparam logic [19:0] c_ZLOW   = 20'h40000;
    localparam logic [19:0] c_MDROUT = 20'h20000;
    localparam logic [19:0] c_COUT   = 20'h10000;
    localparam logic [19:0] c_ROUT   = 20'h08000;
    localparam logic [19:0] c_BAOUT  = 20'h04000;
    localparam logic [19:0] c_MAR    = 20'h02000;
    localparam logic [19:0] c_MDR    = 20'h01000;
    localparam logic [19:0] c_IR     = 20'h00800;
    localparam logic [19:0] c_Y      = 20'h00400;
    localparam logic [19:0] c_Z      = 20'h00200;
    localparam logic [19:0] c_PC     = 20'h00100;
    localparam logic [19:0] c_RAM    = 20'h00080;
    localparam logic [19:0] c_GRA    = 20'h00040;
    localparam logic [19:0] c_GRB    = 20'h00020;
    localparam logic [19:0] c_GRC    = 20'h00010;
    localparam logic [19:0] c_RIN    = 20'h00008;
    localparam logic [19:0] c_INCPC  = 20'h00004;
    localparam logic [19:0] c_READ   = 20'h00002;
    localparam logic [19:0] c_CONIN  = 20'h00001;

    localparam logic [4:0]  c_ALU    = 5'b00011;
    localparam logic [25:0] c_OFF    = 26'd0;
    localparam logic [25:0] c_IDLE   = 26'd1;
    localparam logic [25:0] c_T0     = {c_PCOUT | c_MAR | c_INCPC, 5'd0, 1'b1};
    localparam logic [25:0] c_T1     = {c_READ | c_MDR, 5'd0, 1'b1};
    localparam logic [25:0] c_T2     = {c_MDROUT | c_IR, 5'd0, 1'b1};

    logic Clock;
    logic clear;
    int   n_checks;
    int   n_errors;

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus)
    );

    wire [25:0] w_obs = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.Rout, bus.BAout,
                         bus.enableMAR, bus.enableMDR, bus.enableIR, bus.enableY, bus.enableZ,
                         bus.enablePC, bus.enableRAM, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                         bus.IncPC, bus.Read, bus.conIn, bus.opcode, bus.run};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        n_checks++;
        if (w_obs !== c_OFF) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected %h", w_obs, c_OFF);
        end
        clear = 1'b0;
        tick();
        n_checks++;
        if (w_obs !== c_T0) begin
            n_errors++;
            $display("FAIL reset_to_T0: got %h expected %h", w_obs, c_T0);
        end
    endtask

    task automatic test_ldi();
        logic [25:0] exp [7];
        bus.IR = 32'h09800065;
        exp = '{c_T0, c_T1, c_T2,
                {c_GRB | c_BAOUT | c_Y, 5'd0, 1'b1},
                {c_COUT | c_Z, c_ALU, 1'b1},
                {c_ZLOW | c_GRA | c_RIN, 5'd0, 1'b1},
                c_T0};
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL ldi step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_alu(input logic [31:0] ir, input logic [4:0] alu_op, input bit imm);
        logic [25:0] exp [7];
        bus.IR = ir;
        exp = '{c_T0, c_T1, c_T2,
                {c_GRB | c_ROUT | c_Y, 5'd0, 1'b1},
                imm ? {c_COUT | c_Z, c_ALU, 1'b1} : {c_GRC | c_ROUT | c_Z, alu_op, 1'b1},
                {c_ZLOW | c_GRA | c_RIN, 5'd0, 1'b1},
                c_T0};
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL alu ir=%h step %0d: got %h expected %h", ir, i, w_obs, exp[i]);
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_ld_st();
        logic [25:0] exp [9];
        bus.IR = 32'h00000000;
        exp = '{c_T0, c_T1, c_T2,
                {c_GRB | c_BAOUT | c_Y, 5'd0, 1'b1},
                {c_COUT | c_Z, c_ALU, 1'b1},
                {c_ZLOW | c_MAR, 5'd0, 1'b1},
                {c_READ | c_MDR, 5'd0, 1'b1},
                {c_MDROUT | c_GRA | c_RIN, 5'd0, 1'b1},
                c_T0};
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL ld step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            if (i < 8) tick();
        end
        bus.IR = 32'h10000000;
        exp[6] = {c_GRA | c_ROUT | c_MDR, 5'd0, 1'b1};
        exp[7] = {c_RAM, 5'd0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL st step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            if (i < 8) tick();
        end
    endtask

    task automatic test_br(input logic cond);
        logic [25:0] exp [8];
        bus.IR     = 32'h90000000;
        bus.con_ff = cond;
        exp = '{c_T0, c_T1, c_T2,
                {c_GRA | c_ROUT | c_CONIN, 5'd0, 1'b1},
                {c_PCOUT | c_Y, 5'd0, 1'b1},
                {c_COUT | c_Z, c_ALU, 1'b1},
                cond ? {c_ZLOW | c_PC, 5'd0, 1'b1} : c_IDLE,
                c_T0};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL br con=%0b step %0d: got %h expected %h", cond, i, w_obs, exp[i]);
            end
            if (i < 7) tick();
        end
        bus.con_ff = 1'b0;
    endtask

    task automatic test_nop();
        logic [25:0] exp [5];
        bus.IR = 32'hD0000000;
        exp = '{c_T0, c_T1, c_T2, c_IDLE, c_T0};
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL nop step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_clear_mid();
        logic [25:0] exp [8];
        bus.IR = 32'h00000000;
        exp = '{c_T0, c_T1, c_T2,
                {c_GRB | c_BAOUT | c_Y, 5'd0, 1'b1},
                {c_COUT | c_Z, c_ALU, 1'b1},
                {c_ZLOW | c_MAR, 5'd0, 1'b1},
                c_OFF, c_T0};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL clear_mid step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            clear = (i == 5);
            if (i < 7) tick();
        end
    endtask

    task automatic test_stop();
        logic [25:0] exp [10];
        bus.IR = 32'h1A9A0000;
        exp = '{c_T0, c_T1, c_T2,
                {c_GRB | c_ROUT | c_Y, 5'd0, 1'b1},
                {c_GRC | c_ROUT | c_Z, c_ALU, 1'b1},
                {c_ZLOW | c_GRA | c_RIN, 5'd0, 1'b1},
                c_OFF, c_OFF, c_OFF, c_T0};
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL stop step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            if (i == 4) bus.stop = 1'b1;
            if (i == 7) begin bus.stop = 1'b0; clear = 1'b1; end
            if (i == 8) clear = 1'b0;
            if (i < 9) tick();
        end
    endtask

    task automatic test_halt();
        logic [25:0] exp [8];
        bus.IR = 32'hD8000000;
        exp = '{c_T0, c_T1, c_T2, c_IDLE, c_OFF, c_OFF, c_OFF, c_T0};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL halt step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            clear = (i == 5);
            if (i < 7) tick();
        end
    endtask

    task automatic test_undefined();
`ifdef CTRL_ILLEGAL_TRAP_EN
        logic [25:0] exp [8];
        logic        exp_ill [8];
        bus.IR  = 32'hF8000000;
        exp     = '{c_T0, c_T1, c_T2, c_IDLE, c_OFF, c_OFF, c_OFF, c_T0};
        exp_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_obs !== exp[i] || bus.illegal !== exp_ill[i]) begin
                n_errors++;
                $display("FAIL trap step %0d: got %h/%b expected %h/%b",
                         i, w_obs, bus.illegal, exp[i], exp_ill[i]);
            end
            clear = (i == 5);
            if (i < 7) tick();
        end
`else
        logic [25:0] exp [5];
        bus.IR = 32'hF8000000;
        exp = '{c_T0, c_T1, c_T2, c_IDLE, c_T0};
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (w_obs !== exp[i]) begin
                n_errors++;
                $display("FAIL undef_nop step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            if (i < 4) tick();
        end
`endif
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        clear      = 1'b1;
        bus.IR     = 32'h0;
        bus.con_ff = 1'b0;
        bus.stop   = 1'b0;
        test_reset();
        test_ldi();
        test_alu(32'h1A9A0000, 5'b00011, 1'b0);
        test_alu(32'h20000000, 5'b00100, 1'b0);
        test_alu(32'h30000000, 5'b00110, 1'b0);
        test_alu(32'h60000000, 5'b00011, 1'b1);
        test_ld_st();
        test_br(1'b0);
        test_br(1'b1);
        test_nop();
        test_clear_mid();
        test_stop();
        test_halt();
        test_undefined();
        test_nop();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
